regfile_wen_decoder: RTL and testbench
======================================

// Module: regfile_wen_decoder
//
// PURPOSE
//  Parametrised, registered write-enable decoder for the register file. Decodes two
//  independent write ports (A, B) into a single one-hot/two-hot word-enable vector.
//  Masks writes to the hard-wired zero register and resolves same-address collisions.
//  Adds a pipeline register with stall and a saturating collision counter for debug.
//  Sits between the writeback stage and the register file word-enable inputs.
//
// PARAMETERS
//  ADDR_W     5    address width; NOUT = 2**ADDR_W outputs (localparam, not overridable)
//  ZERO_EN    1    1 = writes to index ZERO_IDX are discarded; 0 = no masking
//  ZERO_IDX   31   index of the hard-wired zero register (0 <= ZERO_IDX < NOUT)
//  CNT_W      8    width of the collision counter
//
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       asynchronous active-low reset
//  stall      in   1       1 = hold all registered state this cycle
//  a_en       in   1       port A write request
//  a_addr     in   ADDR_W  port A register index
//  b_en       in   1       port B write request
//  b_addr     in   ADDR_W  port B register index
//  cnt_clr    in   1       synchronous clear of coll_cnt
//  wen_q      out  NOUT    registered word enables, bit i = write register i
//  a_hit_q    out  1       registered: port A write accepted
//  b_hit_q    out  1       registered: port B write accepted
//  coll_q     out  1       registered: A/B same-address collision this request
//  coll_cnt   out  CNT_W   saturating count of collisions since reset/clear
//
// BEHAVIOUR
//  - Reset (reset_n=0, async): wen_q=0, a_hit_q=0, b_hit_q=0, coll_q=0, coll_cnt=0.
//    Takes effect immediately, regardless of clk, stall or in-flight requests.
//  - Latency: exactly 1 cycle. Inputs sampled at edge k appear on outputs after edge k.
//  - Masking (ZERO_EN=1):
//    - mask_a = a_addr==ZERO_IDX; mask_b = b_addr==ZERO_IDX.
//    - A masked request sets no wen bit and no hit flag.
//    - A masked request never counts as a collision.
//  - Acceptance:
//    - acc_a = a_en & ~mask_a.
//    - acc_b = b_en & ~mask_b & ~(acc_a & a_addr==b_addr).
//  - Collision: coll = acc_a & b_en & ~mask_b & (a_addr==b_addr).
//    - Port A wins; B is dropped (b_hit_q=0) and coll_q=1.
//  - Next state:
//    - wen_q = (acc_a ? onehot(a_addr) : 0) | (acc_b ? onehot(b_addr) : 0).
//    - wen_q popcount is always 0, 1 or 2; never 2 bits for one address.
//  - stall=1: wen_q, hit flags, coll_q and coll_cnt all hold. Inputs are ignored.
//    - Upstream keeps its request asserted across a stall.
//  - coll_cnt precedence, evaluated only when stall=0:
//    - cnt_clr=1 -> 0. Clear wins over a simultaneous collision.
//    - else coll=1 and coll_cnt < 2**CNT_W-1 -> +1.
//    - else hold. Saturates at all-ones, no wrap.
//  - No enables (a_en=b_en=0): all outputs 0 next cycle, except coll_cnt, which holds.
//  - All addresses in range by construction (NOUT = 2**ADDR_W). No X propagation:
//    outputs are defined for every input combination out of reset.
//
// TESTING
//  1. Reset: drive reset_n=0 mid-stream with a_en=1 -> all outputs 0 immediately
//     and on the next edge.
//  2. Single write: a_en=1, a_addr=5, b_en=0 -> next cycle wen_q=32'h0000_0020,
//     a_hit_q=1, b_hit_q=0.
//  3. Dual write: a_addr=3, b_addr=7, both enabled -> wen_q=32'h0000_0088,
//     both hits=1, coll_q=0.
//  4. Collision + zero mask:
//     - a=b=9 -> wen_q=32'h0000_0200, b_hit_q=0, coll_q=1, coll_cnt=1.
//     - a_addr=31, b_addr=31 -> wen_q=0, coll_q=0, coll_cnt unchanged.
//  5. Stall: load a_addr=2, then stall=1 for 3 cycles with a_addr=4 -> wen_q stays
//     32'h4. After release -> 32'h10.
//  6. Counter: CNT_W=2, 5 consecutive collisions -> coll_cnt 1,2,3,3,3.
//     cnt_clr with a collision in the same cycle -> 0.

Source files
------------

// File: rtl/regfile_wen_decoder_if.sv
// Bundle of request and result signals between the writeback stage and the
// register-file write-enable decoder.
interface regfile_wen_decoder_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 8
);
    localparam int NOUT = 1 << ADDR_W;

    logic              stall;
    logic              a_en;
    logic [ADDR_W-1:0] a_addr;
    logic              b_en;
    logic [ADDR_W-1:0] b_addr;
    logic              cnt_clr;
    logic [NOUT-1:0]   wen_q;
    logic              a_hit_q;
    logic              b_hit_q;
    logic              coll_q;
    logic [CNT_W-1:0]  coll_cnt;

    // Writeback side: issues requests, observes decoded enables
    modport master (
        output stall, a_en, a_addr, b_en, b_addr, cnt_clr,
        input  wen_q, a_hit_q, b_hit_q, coll_q, coll_cnt
    );

    // Decoder side: consumes requests, produces registered enables
    modport slave (
        input  stall, a_en, a_addr, b_en, b_addr, cnt_clr,
        output wen_q, a_hit_q, b_hit_q, coll_q, coll_cnt
    );
endinterface

// File: rtl/regfile_wen_decoder.sv
// Registered two-port write-enable decoder for the register file. Port A wins
// same-address collisions, writes to the hard-wired zero register are dropped,
// and a saturating counter tracks collisions for debug.
module regfile_wen_decoder #(
    parameter int ADDR_W   = 5,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_IDX = 31,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    regfile_wen_decoder_if.slave bus
);
    localparam int                NOUT      = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic              maskA;
    logic              maskB;
    logic              sameAddr;
    logic              accA;
    logic              accB;
    logic              coll;
    logic [NOUT-1:0]   wen_d;
    logic [CNT_W-1:0]  collCnt_d;

    logic [NOUT-1:0]   wen_q;
    logic              aHit_q;
    logic              bHit_q;
    logic              coll_q;
    logic [CNT_W-1:0]  collCnt_q;

    // Decode both ports into the next enable word; A has priority on a shared address
    always_comb begin
        maskA    = (ZERO_EN != 0) && (bus.a_addr == ZERO_ADDR);
        maskB    = (ZERO_EN != 0) && (bus.b_addr == ZERO_ADDR);
        sameAddr = (bus.a_addr == bus.b_addr);
        accA     = bus.a_en && !maskA;
        coll     = accA && bus.b_en && !maskB && sameAddr;
        accB     = bus.b_en && !maskB && !(accA && sameAddr);
        wen_d    = '0;
        if (accA) begin
            wen_d[bus.a_addr] = 1'b1;
        end
        if (accB) begin
            wen_d[bus.b_addr] = 1'b1;
        end
    end

    // Collision counter next value: clear beats increment, and it sticks at all-ones
    always_comb begin
        collCnt_d = collCnt_q;
        if (bus.cnt_clr) begin
            collCnt_d = '0;
        end else if (coll && (collCnt_q != CNT_MAX)) begin
            collCnt_d = collCnt_q + 1'b1;
        end
    end

    // Pipeline register; a stall freezes every registered output including the counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wen_q     <= '0;
            aHit_q    <= 1'b0;
            bHit_q    <= 1'b0;
            coll_q    <= 1'b0;
            collCnt_q <= '0;
        end else if (!bus.stall) begin
            wen_q     <= wen_d;
            aHit_q    <= accA;
            bHit_q    <= accB;
            coll_q    <= coll;
            collCnt_q <= collCnt_d;
        end
    end

    assign bus.wen_q    = wen_q;
    assign bus.a_hit_q  = aHit_q;
    assign bus.b_hit_q  = bHit_q;
    assign bus.coll_q   = coll_q;
    assign bus.coll_cnt = collCnt_q;
endmodule

// File: tb/tb_regfile_wen_decoder.sv
// Testbench for regfile_wen_decoder: two instances (8-bit and 2-bit collision
// counters) share one stimulus stream and are compared every cycle against a
// behavioural model, with directed literal checks pinning the model.
module tb_regfile_wen_decoder;
    logic       clk;
    logic       reset_n;
    logic       stall;
    logic       aEn;
    logic [4:0] aAddr;
    logic       bEn;
    logic [4:0] bAddr;
    logic       cntClr;
    bit         checking;
    int         testsRun;
    int         testsFailed;

    // Behavioural model state
    logic [31:0] mWen;
    bit          mAHit;
    bit          mBHit;
    bit          mColl;
    int          mCnt8;
    int          mCnt2;

    regfile_wen_decoder_if #(.ADDR_W(5), .CNT_W(8)) bus8 ();
    regfile_wen_decoder_if #(.ADDR_W(5), .CNT_W(2)) bus2 ();

    assign bus8.stall   = stall;
    assign bus8.a_en    = aEn;
    assign bus8.a_addr  = aAddr;
    assign bus8.b_en    = bEn;
    assign bus8.b_addr  = bAddr;
    assign bus8.cnt_clr = cntClr;
    assign bus2.stall   = stall;
    assign bus2.a_en    = aEn;
    assign bus2.a_addr  = aAddr;
    assign bus2.b_en    = bEn;
    assign bus2.b_addr  = bAddr;
    assign bus2.cnt_clr = cntClr;

    regfile_wen_decoder #(.ADDR_W(5), .ZERO_EN(1), .ZERO_IDX(31), .CNT_W(8)) dut8 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus8.slave)
    );

    regfile_wen_decoder #(.ADDR_W(5), .ZERO_EN(1), .ZERO_IDX(31), .CNT_W(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: work out which registers get written from the request set
    always @(posedge clk or negedge reset_n) begin : model
        bit aWrites;
        bit bWants;
        if (!reset_n) begin
            mWen  = '0;
            mAHit = 0;
            mBHit = 0;
            mColl = 0;
            mCnt8 = 0;
            mCnt2 = 0;
        end else if (!stall) begin
            aWrites = aEn && (aAddr != 5'd31);
            bWants  = bEn && (bAddr != 5'd31);
            mColl   = aWrites && bWants && (aAddr == bAddr);
            mAHit   = aWrites;
            mBHit   = bWants && !mColl;
            mWen    = '0;
            if (mAHit) mWen = mWen | (32'd1 << aAddr);
            if (mBHit) mWen = mWen | (32'd1 << bAddr);
            if (cntClr) begin
                mCnt8 = 0;
                mCnt2 = 0;
            end else if (mColl) begin
                mCnt8 = (mCnt8 < 255) ? mCnt8 + 1 : 255;
                mCnt2 = (mCnt2 < 3) ? mCnt2 + 1 : 3;
            end
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Every falling edge, both instances must agree with the model
    always @(negedge clk) begin
        if (checking) begin
            checkVal("model.wen8", bus8.wen_q, mWen);
            checkVal("model.wen2", bus2.wen_q, mWen);
            checkVal("model.aHit", {30'd0, bus8.a_hit_q, bus2.a_hit_q}, {30'd0, mAHit, mAHit});
            checkVal("model.bHit", {30'd0, bus8.b_hit_q, bus2.b_hit_q}, {30'd0, mBHit, mBHit});
            checkVal("model.coll", {30'd0, bus8.coll_q, bus2.coll_q}, {30'd0, mColl, mColl});
            checkVal("model.cnt8", {24'd0, bus8.coll_cnt}, 32'(mCnt8));
            checkVal("model.cnt2", {30'd0, bus2.coll_cnt}, 32'(mCnt2));
        end
    end

    task automatic applyStimulus(input bit ae, input logic [4:0] aa, input bit be,
                                 input logic [4:0] ba, input bit st, input bit clr);
        aEn    = ae;
        aAddr  = aa;
        bEn    = be;
        bAddr  = ba;
        stall  = st;
        cntClr = clr;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] expWen, input bit expA,
                               input bit expB, input bit expColl, input int expCnt2,
                               input int expCnt8);
        checkVal({name, ".wen"}, bus2.wen_q, expWen);
        checkVal({name, ".aHit"}, {31'd0, bus2.a_hit_q}, {31'd0, expA});
        checkVal({name, ".bHit"}, {31'd0, bus2.b_hit_q}, {31'd0, expB});
        checkVal({name, ".coll"}, {31'd0, bus2.coll_q}, {31'd0, expColl});
        checkVal({name, ".cnt2"}, {30'd0, bus2.coll_cnt}, 32'(expCnt2));
        checkVal({name, ".cnt8"}, {24'd0, bus8.coll_cnt}, 32'(expCnt8));
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        checking    = 0;
        reset_n     = 1'b0;
        aEn = 0; aAddr = '0; bEn = 0; bAddr = '0; stall = 0; cntClr = 0;
        repeat (2) @(negedge clk);
        reset_n  = 1'b1;
        checking = 1;
        checkOutput("reset", 32'h0, 0, 0, 0, 0, 0);

        applyStimulus(1, 5'd5, 0, 5'd0, 0, 0);
        checkOutput("single", 32'h0000_0020, 1, 0, 0, 0, 0);

        applyStimulus(1, 5'd3, 1, 5'd7, 0, 0);
        checkOutput("dual", 32'h0000_0088, 1, 1, 0, 0, 0);

        applyStimulus(1, 5'd9, 1, 5'd9, 0, 0);
        checkOutput("collide", 32'h0000_0200, 1, 0, 1, 1, 1);

        applyStimulus(1, 5'd31, 1, 5'd31, 0, 0);
        checkOutput("zeroMask", 32'h0, 0, 0, 0, 1, 1);

        applyStimulus(0, 5'd31, 1, 5'd31, 0, 0);
        checkOutput("zeroMaskB", 32'h0, 0, 0, 0, 1, 1);

        applyStimulus(1, 5'd2, 0, 5'd0, 0, 0);
        checkOutput("preStall", 32'h4, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'd4, 1, 5'd4, 1, 1);
            checkOutput("stallHold", 32'h4, 1, 0, 0, 1, 1);
        end
        applyStimulus(1, 5'd4, 0, 5'd0, 0, 0);
        checkOutput("stallRelease", 32'h10, 1, 0, 0, 1, 1);

        applyStimulus(0, 5'd0, 0, 5'd0, 0, 1);
        checkOutput("clear", 32'h0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 5'd6, 1, 5'd6, 0, 0);
            checkOutput("saturate", 32'h40, 1, 0, 1, (i < 3) ? i : 3, i);
        end
        applyStimulus(1, 5'd6, 1, 5'd6, 0, 1);
        checkOutput("clearWins", 32'h40, 1, 0, 1, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            logic [4:0] a;
            logic [4:0] b;
            a = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) a = 5'd31;
            b = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0, b,
                          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
        end

        applyStimulus(1, 5'd12, 1, 5'd12, 0, 0);
        #2 reset_n = 1'b0;
        #1 checkOutput("asyncReset", 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("resetHeld", 32'h0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

        for (int i = 0; i < 1500; i++) begin
            logic [4:0] a;
            logic [4:0] b;
            a = 5'($urandom_range(0, 31));
            b = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
            applyStimulus($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0, b,
                          $urandom_range(0, 5) == 0, $urandom_range(0, 31) == 0);
        end

        checking = 0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
